// File: rtl/program_memory.sv
// Loadable program store: streamed load into a word memory, then 1-cycle fetch.
// Optional even-parity protection per word when PROG_MEM_PARITY_EN is defined.
module program_memory #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_oob,
    output logic [ADDR_W:0]   prog_len,
    output logic              loaded
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en_c;
    logic last_word_c;
    logic fetch_hit_c;

    // A word offered alongside load_start belongs to the abandoned load and is dropped.
    assign wr_en_c     = ld_ready && ld_valid && !load_start;
    assign last_word_c = ld_last || (LEN_W'(wr_ptr) == LEN_W'(DEPTH - 1));
    assign fetch_hit_c = (state == RUN) && !load_start && (LEN_W'(fetch_addr) < prog_len);

    // Storage is deliberately not reset; validity is tracked by state and prog_len.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    // Load control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wr_ptr   <= '0;
            prog_len <= '0;
            ld_ready <= 1'b0;
            loaded   <= 1'b0;
        end else begin
            case (state)
                EMPTY, RUN: begin
                    if (load_start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        prog_len <= '0;
                        ld_ready <= 1'b1;
                        loaded   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_ptr   <= '0;
                        prog_len <= '0;
                    end else if (wr_en_c) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (last_word_c) begin
                            state    <= RUN;
                            prog_len <= LEN_W'(wr_ptr) + LEN_W'(1);
                            ld_ready <= 1'b0;
                            loaded   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    ld_ready <= 1'b0;
                    loaded   <= 1'b0;
                end
            endcase
        end
    end

    // Fetch port: result and out-of-range flag hold between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_WORD;
            fetch_oob   <= 1'b0;
        end else begin
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                if (fetch_hit_c) begin
                    fetch_instr <= mem[fetch_addr];
                    fetch_oob   <= 1'b0;
                end else begin
                    fetch_instr <= NOP_WORD;
                    fetch_oob   <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            par_mem[wr_ptr] <= ^ld_data;
        end
    end

    // Only a valid in-range fetch can report a parity mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= fetch_req && fetch_hit_c
                          && (par_mem[fetch_addr] != (^mem[fetch_addr]));
        end
    end
`endif

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: program-level reference model checked every cycle,
// plus directed load/fetch scenarios with literal expectations.
module tb_program_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_addr = 8'h00;
    logic        fetch_valid;
    logic [7:0]  fetch_instr;
    logic        fetch_oob;
    logic [8:0]  prog_len;
    logic        loaded;
`ifdef PROG_MEM_PARITY_EN
    logic        parity_err;
`endif

    int errors = 0;
    int checks = 0;

    program_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .NOP_WORD(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_oob  (fetch_oob),
        .prog_len   (prog_len),
        .loaded     (loaded)
`ifdef PROG_MEM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the committed program, the words of a load in progress,
    // and the expected fetch result.
    logic [7:0] prog [256];
    logic [7:0] stage [$];
    bit         m_loading = 0;
    bit         m_running = 0;
    int         m_plen = 0;
    bit         exp_valid = 0;
    logic [7:0] exp_instr = 8'h00;
    bit         exp_oob = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading = 0;
            m_running = 0;
            m_plen    = 0;
            stage.delete();
            exp_valid = 0;
            exp_instr = 8'h00;
            exp_oob   = 0;
        end else begin
            if (fetch_req) begin
                exp_valid = 1;
                if (m_running && !load_start && int'(fetch_addr) < m_plen) begin
                    exp_instr = prog[fetch_addr];
                    exp_oob   = 0;
                end else begin
                    exp_instr = 8'h00;
                    exp_oob   = 1;
                end
            end else begin
                exp_valid = 0;
            end
            if (load_start) begin
                m_loading = 1;
                m_running = 0;
                m_plen    = 0;
                stage.delete();
            end else if (m_loading && ld_valid) begin
                stage.push_back(ld_data);
                if (ld_last || stage.size() == 256) begin
                    foreach (stage[i]) prog[i] = stage[i];
                    m_plen    = stage.size();
                    m_running = 1;
                    m_loading = 0;
                end
            end
        end
    end

    // Compare all outputs against the model midway through every cycle.
    always @(negedge clk) begin
        chk("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
        chk("fetch_instr", 32'(fetch_instr), 32'(exp_instr));
        chk("fetch_oob",   32'(fetch_oob),   32'(exp_oob));
        chk("ld_ready",    32'(ld_ready),    32'(m_loading));
        chk("loaded",      32'(loaded),      32'(m_running));
        chk("prog_len",    32'(prog_len),    32'(m_plen));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_oob",   32'(fetch_oob),   32'd0);
        chk("rst_prog_len",    32'(prog_len),    32'd0);
        chk("rst_ld_ready",    32'(ld_ready),    32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch while empty.
        fetch(8'd0);
        chk("empty_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("empty_fetch_instr", 32'(fetch_instr), 32'h00);
        chk("empty_fetch_oob",   32'(fetch_oob),   32'd1);
        chk("empty_loaded",      32'(loaded),      32'd0);

        // Three-word program.
        start_load();
        send_word(8'hAC, 1'b0);
        send_word(8'h76, 1'b0);
        send_word(8'hFF, 1'b1);
        chk("p3_prog_len", 32'(prog_len), 32'd3);
        chk("p3_loaded",   32'(loaded),   32'd1);
        fetch(8'd1);
        chk("p3_f1_instr", 32'(fetch_instr), 32'h76);
        chk("p3_f1_oob",   32'(fetch_oob),   32'd0);
        tick();
        chk("hold_valid", 32'(fetch_valid), 32'd0);
        chk("hold_instr", 32'(fetch_instr), 32'h76);
        fetch(8'd3);
        chk("p3_f3_instr", 32'(fetch_instr), 32'h00);
        chk("p3_f3_oob",   32'(fetch_oob),   32'd1);
        fetch_req = 1'b1;
        fetch_addr = 8'd0; tick();
        chk("b2b_0", 32'(fetch_instr), 32'hAC);
        fetch_addr = 8'd1; tick();
        chk("b2b_1", 32'(fetch_instr), 32'h76);
        fetch_addr = 8'd2; tick();
        chk("b2b_2", 32'(fetch_instr), 32'hFF);
        fetch_req = 1'b0;
        tick();

        // Restart mid-load; the word offered with load_start is dropped.
        start_load();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        load_start = 1'b1;
        send_word(8'h99, 1'b0);
        load_start = 1'b0;
        send_word(8'h33, 1'b1);
        chk("restart_prog_len", 32'(prog_len), 32'd1);
        fetch(8'd0);
        chk("restart_f0", 32'(fetch_instr), 32'h33);

        // Fetch coinciding with load_start in RUN, then during LOAD.
        load_start = 1'b1;
        fetch(8'd0);
        load_start = 1'b0;
        chk("ls_fetch_oob", 32'(fetch_oob), 32'd1);
        fetch(8'd0);
        chk("load_fetch_oob", 32'(fetch_oob), 32'd1);

        // Full-depth load with no ld_last.
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i) ^ 8'h5A, 1'b0);
        end
        chk("full_loaded",   32'(loaded),   32'd1);
        chk("full_prog_len", 32'(prog_len), 32'd256);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        fetch(8'd255);
        chk("full_f255", 32'(fetch_instr), 32'hA5);
        chk("full_f255_oob", 32'(fetch_oob), 32'd0);

        // Reset in the middle of a load.
        start_load();
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstld_prog_len", 32'(prog_len), 32'd0);
        chk("rstld_loaded",   32'(loaded),   32'd0);
        chk("rstld_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch(8'd0);
        chk("rstld_f0_instr", 32'(fetch_instr), 32'h00);
        chk("rstld_f0_oob",   32'(fetch_oob),   32'd1);

`ifdef PROG_MEM_PARITY_EN
        start_load();
        send_word(8'h01, 1'b0);
        send_word(8'h03, 1'b1);
        dut.par_mem[1] = ~dut.par_mem[1];
        fetch(8'd1);
        chk("parity_err_1", 32'(parity_err), 32'd1);
        fetch(8'd0);
        chk("parity_err_0", 32'(parity_err), 32'd0);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words, at most 2**ADDR_W.
REQ-004 The block SHALL have parameter NOP_WORD, default 0, the word returned for any non-valid fetch.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 load_start  in  1  one-cycle pulse that begins a program load.
REQ-009 ld_valid  in  1  load word present.
REQ-010 ld_data  in  DATA_W  load word.
REQ-011 ld_last  in  1  marks the final load word.
REQ-012 ld_ready  out  1  block accepts a load word.
REQ-013 fetch_req  in  1  fetch request.
REQ-014 fetch_addr  in  ADDR_W  word address (program counter).
REQ-015 fetch_valid  out  1  fetch_instr is valid.
REQ-016 fetch_instr  out  DATA_W  fetched instruction.
REQ-017 fetch_oob  out  1  last fetch was out of range or made while not in RUN.
REQ-018 prog_len  out  ADDR_W+1  number of words loaded.
REQ-019 loaded  out  1  high while in RUN.

Function
REQ-020 The state machine SHALL have states EMPTY, LOAD and RUN.
REQ-021 load_start in EMPTY or RUN SHALL move to LOAD next cycle, clear the write pointer and clear prog_len to 0.
REQ-022 In LOAD, ld_ready SHALL be 1; ld_ready SHALL be 0 in EMPTY and RUN.
REQ-023 Each cycle with ld_valid and ld_ready high SHALL write ld_data to mem[wr_ptr] and increment wr_ptr.
REQ-024 An accepted word with ld_last high, or written to address DEPTH-1, SHALL end the load: go to RUN, set prog_len to wr_ptr+1.
REQ-025 load_start during LOAD SHALL restart the load at pointer 0; any word offered in that same cycle SHALL be dropped.
REQ-026 A fetch SHALL have 1-cycle latency: fetch_req at edge N gives fetch_valid=1 with data after edge N+1; fetch_valid SHALL be 0 otherwise.
REQ-027 In RUN, with fetch_addr < prog_len, the fetch SHALL return mem[fetch_addr] with fetch_oob=0.
REQ-028 In RUN, with fetch_addr >= prog_len, the fetch SHALL return NOP_WORD with fetch_oob=1.
REQ-029 In EMPTY or LOAD, or in a cycle with load_start high, the fetch SHALL return NOP_WORD with fetch_oob=1.
REQ-030 fetch_instr and fetch_oob SHALL hold their values when there is no fetch.
REQ-031 Back-to-back fetches SHALL be supported every cycle.

Reset
REQ-032 Reset SHALL force EMPTY, with ld_ready=0, fetch_valid=0, fetch_instr=NOP_WORD, fetch_oob=0, prog_len=0, loaded=0 and wr_ptr=0.
REQ-033 Memory contents SHALL NOT be cleared by reset; they are unreadable until a new load completes.
REQ-034 Reset during LOAD SHALL abandon the load; the partial program SHALL NOT be fetchable.

Configuration
REQ-035 The macro PROG_MEM_PARITY_EN, when defined, SHALL store an even-parity bit with each word and add output parity_err (1 bit).
REQ-036 parity_err SHALL be registered with fetch_valid, and SHALL be 1 when the stored parity of a valid in-range fetch mismatches; it SHALL reset to 0.
REQ-037 When PROG_MEM_PARITY_EN is undefined, the parity storage and the parity_err port SHALL be absent.

Verification
REQ-038 Reset, then fetch addr 0 -> fetch_valid=1, fetch_instr=0x00, fetch_oob=1, loaded=0.
REQ-039 Load 0xAC,0x76,0xFF with ld_last on the third word -> prog_len=3, loaded=1; fetch 1 -> 0x76 one cycle later, fetch_oob=0.
REQ-040 After REQ-039, fetch 3 -> 0x00, fetch_oob=1; fetches 0,1,2 on consecutive cycles -> 0xAC,0x76,0xFF on consecutive cycles.
REQ-041 Load 256 words without ld_last -> RUN after word 255, prog_len=256, ld_ready=0.
REQ-042 Assert rst_n low after 2 of 3 load words -> EMPTY, prog_len=0; fetch 0 -> 0x00, fetch_oob=1.
REQ-043 With PROG_MEM_PARITY_EN, force the stored parity bit of word 1 to flip, then fetch 1 -> parity_err=1; fetch 0 -> parity_err=0.
